rom_access_scheduler: RTL and testbench
=======================================

# rom_access_scheduler

Sequences the dilation/erosion filter and arbitrates the single asynchronous ROM read port between the VGA scanner and the filter engine. The VGA always owns the ROM during active display. The filter is granted the ROM only during blanking, and only while a filter run is scheduled. The block decides when a run starts, gates filter RAM writes, and selects whether the display shows ROM or RAM data.

## Interface
Parameters:
- ADDR_W, 7, ROM/RAM row address width
- DATA_W, 64, ROM row width
- CNT_W, 16, width of status counters

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- mode_en  in  1  filter display mode (1 = show filtered RAM image)
- cfg  in  2  filter operation select; forwarded to filter
- vga_addr  in  ADDR_W  VGA row read address
- vga_active  in  1  VGA in visible region (ROM reserved for VGA)
- flt_req  in  1  filter ROM read request
- flt_addr  in  ADDR_W  filter ROM read address
- flt_we  in  1  filter RAM write request
- flt_done  in  1  one-cycle pulse: filter finished the full image
- rom_addr  out  ADDR_W  ROM address (muxed)
- flt_gnt  out  1  filter read granted this cycle; rom_data valid for filter
- flt_start  out  1  one-cycle pulse: begin filter pass
- flt_cfg  out  2  cfg latched at the start of the run
- ram_we  out  1  gated RAM write enable
- disp_sel_ram  out  1  1 = display RAM data, 0 = display ROM data
- busy  out  1  run scheduled or in progress
- run_count  out  CNT_W  completed runs, wraps
- stall_count  out  CNT_W  cycles with flt_req=1 and flt_gnt=0 in RUN; saturates at all-ones

## Operation
- FSM states: IDLE, WAIT_BLANK, RUN, DONE.
- IDLE: disp_sel_ram=0.
  - mode_en=1 -> WAIT_BLANK.
- WAIT_BLANK:
  - mode_en=0 -> IDLE.
  - Otherwise, on the first cycle with vga_active=0: pulse flt_start, latch cfg into flt_cfg, go to RUN.
- RUN:
  - flt_gnt = flt_req & ~vga_active (combinational).
  - ram_we = flt_we.
  - flt_done -> DONE and run_count+1.
  - mode_en=0 during RUN: finish the run, then go to IDLE instead of DONE. run_count still increments.
  - cfg != flt_cfg during RUN: set restart_pending. On flt_done, go to WAIT_BLANK (not DONE). run_count still increments.
- DONE: disp_sel_ram=1.
  - mode_en=0 -> IDLE.
  - cfg != flt_cfg -> WAIT_BLANK.
- flt_done outside RUN is ignored.
- rom_addr = flt_addr when flt_gnt=1, else vga_addr.
- Outside RUN: flt_gnt=0, ram_we=0.
- busy = 1 in WAIT_BLANK and RUN.
- stall_count increments only in RUN and saturates at all-ones. Both counters clear only on reset.
- restart_pending clears on leaving RUN.

## Timing
- All state, counters and flt_cfg are registered on rising clk.
- rst=0 at a clock edge forces, on that edge:
  - state=IDLE
  - flt_cfg=0, run_count=0, stall_count=0, restart_pending=0
  - flt_start=0, disp_sel_ram=0, busy=0
- During reset, flt_gnt=0, ram_we=0 and rom_addr=vga_addr.
- Reset mid-RUN abandons the run with no flt_done needed. The next run requires mode_en=1 after reset.
- flt_start is registered and high for exactly one cycle: the cycle in which state first reads RUN.
- Grant path:
  - flt_gnt, rom_addr and ram_we are combinational, with zero-cycle latency from flt_req/vga_active.
  - The filter must hold flt_req/flt_addr until it sees flt_gnt=1.
  - ROM data is sampled by the filter in the granted cycle.
- vga_active rising while the filter is requesting: flt_gnt drops in that same cycle and the VGA gets the ROM immediately.
- flt_done and a cfg change in the same cycle: restart_pending is treated as set, so the FSM goes to WAIT_BLANK.
- flt_done and mode_en=0 in the same cycle: go to IDLE; run_count+1.
- DONE->WAIT_BLANK: disp_sel_ram falls the cycle after the cfg change, so the display never shows a partially rewritten RAM image.

## Test plan
- Reset: rst=0 for 2 cycles with random inputs -> all registered outputs 0, rom_addr=vga_addr, flt_gnt=0.
- Basic run:
  - Stimulus: mode_en=1 with vga_active=1 for 10 cycles, then 0.
  - Required: flt_start pulses once, on the cycle after vga_active falls. flt_cfg=cfg. During flt_req, rom_addr=flt_addr and flt_gnt=1.
  - Then flt_done -> disp_sel_ram=1 next cycle, run_count=1.
- Preemption:
  - Stimulus: in RUN with flt_req=1 and flt_addr=0x15, vga_addr=0x40; raise vga_active for 5 cycles.
  - Required: same-cycle flt_gnt=0 and rom_addr=0x40; stall_count=5.
- Config change mid-run:
  - Stimulus: cfg 01->10 during RUN, then flt_done.
  - Required: state WAIT_BLANK, disp_sel_ram stays 0, second flt_start with flt_cfg=10, run_count=1 after the first done.
- mode_en drop: mode_en=0 in DONE -> IDLE and disp_sel_ram=0 next cycle. In WAIT_BLANK -> IDLE, no flt_start.
- Stall saturation: with CNT_W=4, hold flt_req=1 and vga_active=1 for 20 cycles in RUN -> stall_count=15 and it does not wrap.

Source files
------------

// File: rtl/rom_access_scheduler.sv
// Schedules dilation/erosion filter runs and arbitrates the single ROM read
// port between the VGA scanner (owner during active video) and the filter.
module rom_access_scheduler #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_en,
  input  logic [1:0]        cfg,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_active,
  input  logic              flt_req,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic              flt_we,
  input  logic              flt_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              flt_gnt,
  output logic              flt_start,
  output logic [1:0]        flt_cfg,
  output logic              ram_we,
  output logic              disp_sel_ram,
  output logic              busy,
  output logic [CNT_W-1:0]  run_count,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         flt_cfg_q, flt_cfg_d;
  logic               start_q, start_d;
  logic               restart_q, restart_d;
  logic               stop_q, stop_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               in_run;
  logic               cfg_chg;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Grant path is purely combinational; rst gating keeps the VGA on the ROM
  // even before the first reset edge has cleared the state register.
  assign in_run   = rst && (state_q == RUN);
  assign flt_gnt  = in_run && flt_req && !vga_active;
  assign ram_we   = in_run && flt_we;
  assign rom_addr = flt_gnt ? flt_addr : vga_addr;
  assign cfg_chg  = (cfg != flt_cfg_q);

  assign flt_start    = start_q;
  assign flt_cfg      = flt_cfg_q;
  assign disp_sel_ram = (state_q == DONE);
  assign busy         = (state_q == WAIT_BLANK) || (state_q == RUN);
  assign run_count    = run_cnt_q;
  assign stall_count  = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    flt_cfg_d   = flt_cfg_q;
    start_d     = 1'b0;
    restart_d   = restart_q;
    stop_d      = stop_q;
    run_cnt_d   = run_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (mode_en) state_d = WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (!mode_en) begin
          state_d = IDLE;
        end else if (!vga_active) begin
          state_d   = RUN;
          start_d   = 1'b1;
          flt_cfg_d = cfg;
        end
      end
      RUN: begin
        if (cfg_chg)  restart_d = 1'b1;
        if (!mode_en) stop_d    = 1'b1;
        if (flt_req && vga_active) stall_cnt_d = sat_inc(stall_cnt_q);
        // A mode drop seen at any point in the run wins over a restart.
        if (flt_done) begin
          run_cnt_d = run_cnt_q + 1'b1;
          restart_d = 1'b0;
          stop_d    = 1'b0;
          if (stop_q || !mode_en)        state_d = IDLE;
          else if (restart_q || cfg_chg) state_d = WAIT_BLANK;
          else                           state_d = DONE;
        end
      end
      DONE: begin
        if (!mode_en)     state_d = IDLE;
        else if (cfg_chg) state_d = WAIT_BLANK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      flt_cfg_q   <= 2'b00;
      start_q     <= 1'b0;
      restart_q   <= 1'b0;
      stop_q      <= 1'b0;
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flt_cfg_q   <= flt_cfg_d;
      start_q     <= start_d;
      restart_q   <= restart_d;
      stop_q      <= stop_d;
      run_cnt_q   <= run_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_rom_access_scheduler.sv
// Directed bench for rom_access_scheduler; expected run configurations are
// queued when a start is provoked and checked when flt_start is observed.
module tb_rom_access_scheduler;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode_en;
  logic [1:0]        cfg;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_active;
  logic              flt_req;
  logic [ADDR_W-1:0] flt_addr;
  logic              flt_we;
  logic              flt_done;
  logic [ADDR_W-1:0] rom_addr;
  logic              flt_gnt;
  logic              flt_start;
  logic [1:0]        flt_cfg;
  logic              ram_we;
  logic              disp_sel_ram;
  logic              busy;
  logic [CNT_W-1:0]  run_count;
  logic [CNT_W-1:0]  stall_count;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_cfg_q[$];

  rom_access_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode_en(mode_en), .cfg(cfg), .vga_addr(vga_addr),
    .vga_active(vga_active), .flt_req(flt_req), .flt_addr(flt_addr),
    .flt_we(flt_we), .flt_done(flt_done), .rom_addr(rom_addr),
    .flt_gnt(flt_gnt), .flt_start(flt_start), .flt_cfg(flt_cfg),
    .ram_we(ram_we), .disp_sel_ram(disp_sel_ram), .busy(busy),
    .run_count(run_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every flt_start pulse must match the next queued configuration.
  always @(negedge clk) begin
    if (rst === 1'b1 && flt_start === 1'b1) begin
      if (exp_cfg_q.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
      else                       chk("start_cfg", {30'd0, flt_cfg}, {30'd0, exp_cfg_q.pop_front()});
    end
  end

  initial begin
    rst = 1'b0; mode_en = 1'b0; cfg = 2'b00; vga_addr = '0; vga_active = 1'b0;
    flt_req = 1'b0; flt_addr = '0; flt_we = 1'b0; flt_done = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      mode_en = 1'($urandom); cfg = 2'($urandom); vga_addr = 7'($urandom);
      vga_active = 1'($urandom); flt_req = 1'b1; flt_addr = 7'($urandom);
      flt_we = 1'b1; flt_done = 1'($urandom);
      #1;
      chk("rst_gnt", {31'd0, flt_gnt}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_rom_addr", {25'd0, rom_addr}, {25'd0, vga_addr});
      step();
    end
    chk("rst_start", {31'd0, flt_start}, 32'd0);
    chk("rst_disp", {31'd0, disp_sel_ram}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg", {30'd0, flt_cfg}, 32'd0);
    chk("rst_runs", {28'd0, run_count}, 32'd0);
    chk("rst_stalls", {28'd0, stall_count}, 32'd0);

    // Basic run
    rst = 1'b1; mode_en = 1'b1; cfg = 2'b01; vga_active = 1'b1; vga_addr = 7'h40;
    flt_req = 1'b0; flt_we = 1'b0; flt_done = 1'b0; flt_addr = 7'h15;
    for (int i = 0; i < 10; i++) step();
    chk("wb_busy", {31'd0, busy}, 32'd1);
    chk("wb_no_start", {31'd0, flt_start}, 32'd0);
    vga_active = 1'b0;
    exp_cfg_q.push_back(2'b01);
    step();
    chk("run_start", {31'd0, flt_start}, 32'd1);
    chk("run_cfg", {30'd0, flt_cfg}, 32'd1);
    step();
    chk("start_one_cycle", {31'd0, flt_start}, 32'd0);
    flt_req = 1'b1; flt_we = 1'b1; #1;
    chk("gnt", {31'd0, flt_gnt}, 32'd1);
    chk("gnt_addr", {25'd0, rom_addr}, 32'h15);
    chk("run_we", {31'd0, ram_we}, 32'd1);

    // Preemption by active video
    vga_active = 1'b1; #1;
    chk("preempt_gnt", {31'd0, flt_gnt}, 32'd0);
    chk("preempt_addr", {25'd0, rom_addr}, 32'h40);
    for (int i = 0; i < 5; i++) step();
    chk("stalls5", {28'd0, stall_count}, 32'd5);
    vga_active = 1'b0; flt_req = 1'b0; flt_we = 1'b0;
    step();
    flt_done = 1'b1;
    step();
    flt_done = 1'b0;
    chk("done_disp", {31'd0, disp_sel_ram}, 32'd1);
    chk("done_runs", {28'd0, run_count}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);

    // mode_en drop in DONE, then in WAIT_BLANK
    mode_en = 1'b0;
    step();
    chk("drop_done_disp", {31'd0, disp_sel_ram}, 32'd0);
    chk("drop_done_busy", {31'd0, busy}, 32'd0);
    mode_en = 1'b1; vga_active = 1'b1;
    step();
    chk("wb2_busy", {31'd0, busy}, 32'd1);
    mode_en = 1'b0;
    step();
    chk("drop_wb_busy", {31'd0, busy}, 32'd0);
    vga_active = 1'b0; flt_req = 1'b1; #1;
    chk("idle_gnt", {31'd0, flt_gnt}, 32'd0);
    step();
    chk("drop_wb_no_start", {31'd0, flt_start}, 32'd0);
    flt_req = 1'b0;

    // Config change mid-run
    mode_en = 1'b1; cfg = 2'b01;
    exp_cfg_q.push_back(2'b01);
    step(); step();
    chk("run2_start", {31'd0, flt_start}, 32'd1);
    cfg = 2'b10;
    step();
    flt_done = 1'b1;
    exp_cfg_q.push_back(2'b10);
    step();
    flt_done = 1'b0;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_disp", {31'd0, disp_sel_ram}, 32'd0);
    chk("restart_runs", {28'd0, run_count}, 32'd2);
    step();
    chk("restart_start", {31'd0, flt_start}, 32'd1);
    chk("restart_cfg", {30'd0, flt_cfg}, 32'd2);

    // flt_done coincident with a cfg change
    step();
    flt_done = 1'b1; cfg = 2'b11; vga_active = 1'b1;
    step();
    flt_done = 1'b0;
    chk("coinc_busy", {31'd0, busy}, 32'd1);
    chk("coinc_disp", {31'd0, disp_sel_ram}, 32'd0);
    chk("coinc_runs", {28'd0, run_count}, 32'd3);
    mode_en = 1'b0;
    step();

    // flt_done coincident with mode_en drop; stray done in IDLE
    mode_en = 1'b1; cfg = 2'b00; vga_active = 1'b0;
    exp_cfg_q.push_back(2'b00);
    step(); step();
    mode_en = 1'b0; flt_done = 1'b1;
    step();
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_disp", {31'd0, disp_sel_ram}, 32'd0);
    chk("stop_runs", {28'd0, run_count}, 32'd4);
    step();
    flt_done = 1'b0;
    chk("idle_done_ignored", {28'd0, run_count}, 32'd4);

    // Stall saturation
    mode_en = 1'b1;
    exp_cfg_q.push_back(2'b00);
    step(); step();
    flt_req = 1'b1; vga_active = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", {28'd0, stall_count}, 32'd15);

    // Reset mid-run
    rst = 1'b0;
    step();
    rst = 1'b1; mode_en = 1'b0; flt_req = 1'b0; vga_active = 1'b0;
    chk("rrst_busy", {31'd0, busy}, 32'd0);
    chk("rrst_runs", {28'd0, run_count}, 32'd0);
    chk("rrst_stalls", {28'd0, stall_count}, 32'd0);
    chk("rrst_cfg", {30'd0, flt_cfg}, 32'd0);
    step();
    chk("rrst_idle", {31'd0, busy}, 32'd0);
    chk("sb_empty", exp_cfg_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
